// File: rtl/fc_ibuf_ctrl.sv
// Sequencer for a fully-connected layer input buffer: loads FIFO_LENGTH words, then feeds
// the CIM tile one bit plane at a time (stream NUM_ADDR words, start, wait, shift).
//
// state | meaning
// LOAD  | accept words from the previous layer's output buffer
// WRITE | stream buffer bus words into the crossbar input rows
// EXEC  | one-cycle start pulse to the tile
// WAIT  | wait for the tile to finish the current bit plane
// SHIFT | one-cycle buffer shift to expose the next bit plane
// DONE  | one-cycle completion pulse, back to LOAD
module fc_ibuf_ctrl #(
  parameter int DATA_SIZE   = 8,
  parameter int FIFO_LENGTH = 4,
  parameter int NUM_ADDR    = 2,
  parameter int ADDR_W      = ($clog2(NUM_ADDR) > 0) ? $clog2(NUM_ADDR) : 1,
  parameter int BIT_W       = $clog2(DATA_SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_ibuf_we,
  output logic              o_ibuf_se,
  output logic [ADDR_W-1:0] o_ibuf_addr,
  output logic              o_cim_we,
  input  logic              i_cim_ready,
  output logic              o_cim_start,
  input  logic              i_cim_done,
  output logic [BIT_W-1:0]  o_bit_idx,
  output logic              o_done
);

  localparam int LOAD_W = $clog2(FIFO_LENGTH) + 1;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WRITE = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [LOAD_W-1:0] load_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BIT_W-1:0]  bit_q;

  logic load_acc, cim_hs, last_load, last_addr, last_bit;

  assign load_acc  = (state_q == S_LOAD) && i_in_valid && !rst;
  assign cim_hs    = (state_q == S_WRITE) && i_cim_ready;
  assign last_load = (load_cnt_q == LOAD_W'(FIFO_LENGTH - 1));
  assign last_addr = (addr_q == ADDR_W'(NUM_ADDR - 1));
  assign last_bit  = (bit_q == BIT_W'(DATA_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_acc && last_load) state_d = S_WRITE;
      S_WRITE: if (cim_hs && last_addr) state_d = S_EXEC;
      S_EXEC:  state_d = S_WAIT;
      S_WAIT:  if (i_cim_done) state_d = last_bit ? S_DONE : S_SHIFT;
      S_SHIFT: state_d = S_WRITE;
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Write enable is gated by rst so a word presented during reset is never pushed.
  always_comb begin
    o_in_ready  = (state_q == S_LOAD);
    o_ibuf_we   = load_acc;
    o_cim_we    = (state_q == S_WRITE);
    o_cim_start = (state_q == S_EXEC);
    o_ibuf_se   = (state_q == S_SHIFT);
    o_done      = (state_q == S_DONE);
    o_ibuf_addr = addr_q;
    o_bit_idx   = bit_q;
  end

  // addr_q is cleared on every exit from WRITE, so the address port reads 0 elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt_q <= '0;
      addr_q     <= '0;
      bit_q      <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_acc) begin
            if (last_load) begin
              load_cnt_q <= '0;
              addr_q     <= '0;
              bit_q      <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + LOAD_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (cim_hs) begin
            addr_q <= last_addr ? '0 : addr_q + ADDR_W'(1);
          end
        end
        S_SHIFT: begin
          bit_q  <= bit_q + BIT_W'(1);
          addr_q <= '0;
        end
        S_DONE: begin
          bit_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_ibuf_ctrl.sv
// Directed bench for fc_ibuf_ctrl with DATA_SIZE=2, FIFO_LENGTH=3, NUM_ADDR=2.
// Output vector order: {in_ready, ibuf_we, cim_we, addr, cim_start, ibuf_se, done}.
module tb_fc_ibuf_ctrl;

  localparam int DS = 2;
  localparam int FL = 3;
  localparam int NA = 2;
  localparam int AW = 1;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic          o_ibuf_we;
  logic          o_ibuf_se;
  logic [AW-1:0] o_ibuf_addr;
  logic          o_cim_we;
  logic          i_cim_ready;
  logic          o_cim_start;
  logic          i_cim_done;
  logic [BW-1:0] o_bit_idx;
  logic          o_done;

  int checks = 0;
  int errors = 0;

  wire [6:0] obs = {o_in_ready, o_ibuf_we, o_cim_we, o_ibuf_addr, o_cim_start, o_ibuf_se, o_done};

  fc_ibuf_ctrl #(
    .DATA_SIZE  (DS),
    .FIFO_LENGTH(FL),
    .NUM_ADDR   (NA),
    .ADDR_W     (AW),
    .BIT_W      (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .o_ibuf_we  (o_ibuf_we),
    .o_ibuf_se  (o_ibuf_se),
    .o_ibuf_addr(o_ibuf_addr),
    .o_cim_we   (o_cim_we),
    .i_cim_ready(i_cim_ready),
    .o_cim_start(o_cim_start),
    .i_cim_done (i_cim_done),
    .o_bit_idx  (o_bit_idx),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_in_valid = 1'b0;
    i_cim_ready = 1'b0;
    i_cim_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_in_valid = 1'b1;
    i_cim_ready = 1'b1;
    i_cim_done = 1'b1;
    #2;
    checks++;
    if (obs !== 7'b1000000 || o_bit_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: obs=%b bit=%0d expected obs=1000000 bit=0", obs, o_bit_idx);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 7'b1000000 || o_bit_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_held: obs=%b bit=%0d expected obs=1000000 bit=0", obs, o_bit_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    int nwe;
    nwe = 0;
    do_reset();
    for (int i = 0; i < FL; i++) begin
      i_in_valid = 1'b1;
      #1;
      if (o_ibuf_we === 1'b1) nwe++;
      checks++;
      if (o_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready[%0d]: got %b expected 1", i, o_in_ready);
      end
      cyc();
    end
    checks++;
    if (nwe != FL) begin
      errors++;
      $display("FAIL load_we_count: got %0d expected %0d", nwe, FL);
    end
    i_in_valid = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0010000) begin
      errors++;
      $display("FAIL load_enter_write: obs=%b expected 0010000", obs);
    end
  endtask

  task automatic test_gaps();
    logic [4:0] pat;
    int nwe;
    pat = 5'b10101;
    nwe = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_in_valid = pat[i];
      #1;
      if (o_ibuf_we === 1'b1) nwe++;
      checks++;
      if (o_in_ready !== 1'b1 || o_ibuf_we !== pat[i]) begin
        errors++;
        $display("FAIL gaps_cycle[%0d]: ready=%b we=%b expected ready=1 we=%b", i, o_in_ready, o_ibuf_we, pat[i]);
      end
      cyc();
    end
    i_in_valid = 1'b0;
    #1;
    checks++;
    if (nwe != 3 || obs !== 7'b0010000) begin
      errors++;
      $display("FAIL gaps_result: we_count=%0d obs=%b expected 3 and 0010000", nwe, obs);
    end
  endtask

  task automatic test_full_pass(input string name);
    logic [6:0] exp_o [16];
    logic [BW-1:0] exp_b;
    exp_o = '{7'b1100000, 7'b1100000, 7'b1100000, 7'b0010000,
              7'b0011000, 7'b0000100, 7'b0000000, 7'b0000000,
              7'b0000010, 7'b0010000, 7'b0011000, 7'b0000100,
              7'b0000000, 7'b0000000, 7'b0000001, 7'b1000000};
    for (int c = 0; c < 16; c++) begin
      i_in_valid = (c < 3);
      i_cim_ready = 1'b1;
      i_cim_done = (c == 7 || c == 13);
      exp_b = (c >= 9 && c <= 14) ? 2'd1 : 2'd0;
      #1;
      checks++;
      if (obs !== exp_o[c] || o_bit_idx !== exp_b) begin
        errors++;
        $display("FAIL %s[%0d]: obs=%b bit=%0d expected obs=%b bit=%0d", name, c, obs, o_bit_idx, exp_o[c], exp_b);
      end
      cyc();
    end
    i_cim_done = 1'b0;
  endtask

  task automatic test_backpressure();
    int starts, ses, done_at;
    do_reset();
    for (int i = 0; i < FL; i++) begin
      i_in_valid = 1'b1;
      cyc();
    end
    i_in_valid = 1'b0;
    i_cim_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0010000) begin
      errors++;
      $display("FAIL bp_addr0: obs=%b expected 0010000", obs);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      i_cim_ready = 1'b0;
      #1;
      checks++;
      if (obs !== 7'b0011000) begin
        errors++;
        $display("FAIL bp_stall[%0d]: obs=%b expected 0011000", i, obs);
      end
      cyc();
    end
    i_cim_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0011000) begin
      errors++;
      $display("FAIL bp_release: obs=%b expected 0011000", obs);
    end
    cyc();
    i_cim_ready = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000100) begin
      errors++;
      $display("FAIL bp_exec: obs=%b expected 0000100", obs);
    end
    cyc();
    starts = 0;
    ses = 0;
    done_at = -1;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      i_cim_ready = 1'b1;
      i_cim_done = 1'b1;
      #1;
      if (o_cim_start === 1'b1) starts++;
      if (o_ibuf_se === 1'b1) ses++;
      if (o_done === 1'b1) done_at = c;
      cyc();
    end
    i_cim_done = 1'b0;
    checks++;
    if (done_at != 6 || starts != 1 || ses != 1) begin
      errors++;
      $display("FAIL bp_finish: done_at=%0d starts=%0d se=%0d expected 6 1 1", done_at, starts, ses);
    end
  endtask

  task automatic test_stray();
    do_reset();
    for (int i = 0; i < FL; i++) begin
      i_in_valid = 1'b1;
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      i_in_valid = 1'b1;
      i_cim_ready = 1'b0;
      i_cim_done = 1'b1;
      #1;
      checks++;
      if (obs !== 7'b0010000) begin
        errors++;
        $display("FAIL stray_write_hold[%0d]: obs=%b expected 0010000", i, obs);
      end
      cyc();
    end
    i_cim_done = 1'b0;
    i_cim_ready = 1'b1;
    cyc();
    cyc();
    #1;
    checks++;
    if (obs !== 7'b0000100) begin
      errors++;
      $display("FAIL stray_exec: obs=%b expected 0000100", obs);
    end
    cyc();
    i_cim_done = 1'b1;
    cyc();
    #1;
    checks++;
    if (obs !== 7'b0000010 || o_bit_idx !== 2'd0) begin
      errors++;
      $display("FAIL stray_shift: obs=%b bit=%0d expected 0000010 bit=0", obs, o_bit_idx);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      i_cim_ready = 1'b0;
      #1;
      checks++;
      if (obs !== 7'b0010000 || o_bit_idx !== 2'd1) begin
        errors++;
        $display("FAIL stray_after_shift[%0d]: obs=%b bit=%0d expected 0010000 bit=1", i, obs, o_bit_idx);
      end
      cyc();
    end
    i_in_valid = 1'b0;
    i_cim_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      i_in_valid = (c < 3);
      i_cim_ready = 1'b1;
      i_cim_done = (c == 7);
      cyc();
    end
    i_in_valid = 1'b0;
    i_cim_done = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000000 || o_bit_idx !== 2'd1) begin
      errors++;
      $display("FAIL mid_wait_bit1: obs=%b bit=%0d expected 0000000 bit=1", obs, o_bit_idx);
    end
    rst = 1'b1;
    i_in_valid = 1'b1;
    i_cim_done = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1000000 || o_bit_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_async: obs=%b bit=%0d expected 1000000 bit=0", obs, o_bit_idx);
    end
    cyc();
    checks++;
    if (obs !== 7'b1000000 || o_bit_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_edge: obs=%b bit=%0d expected 1000000 bit=0", obs, o_bit_idx);
    end
    rst = 1'b0;
    i_in_valid = 1'b0;
    i_cim_done = 1'b0;
    test_full_pass("post_reset_pass");
  endtask

  initial begin
    rst = 1'b1;
    i_in_valid = 1'b0;
    i_cim_ready = 1'b0;
    i_cim_done = 1'b0;
    test_reset();
    test_load();
    test_gaps();
    do_reset();
    test_full_pass("full_pass");
    test_backpressure();
    test_stray();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
